gb_timer_ctrl: RTL and testbench

Game Boy timer controller: owns the 16-bit system counter and sequences the DIV, TIMA, TMA and TAC registers from a T-cycle enable. It selects the TIMA clock from a counter bit, handles overflow-delayed reload from TMA and raises the timer interrupt request. It sits between the CPU register bus (0xFF04–0xFF07) and the interrupt controller, clocked from the system clock with a per-T-cycle `tick_in` strobe.

---
 rtl/gb_timer_ctrl.sv | 173 +++++++++++++++++
 tb/tb_gb_timer_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/gb_timer_ctrl.sv
// Game Boy timer controller: system counter, DIV/TIMA/TMA/TAC and delayed TMA reload.
// Optional macro TIMER_DIV_GLITCH_EN: DIV/TAC writes that drop timer_sig also count as a TIMA increment.
module gb_timer_ctrl #(
  parameter int SYS_CNT_WIDTH = 16,
  parameter int RELOAD_DELAY  = 4
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       tick_in,
  input  logic       reg_wr_in,
  input  logic [1:0] reg_addr_in,
  input  logic [7:0] reg_wdata_in,
  output logic [7:0] reg_rdata_out,
  output logic       irq_out,
  output logic [1:0] dbg_state_out
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_OVF    = 2'd1,
    ST_RELOAD = 2'd2
  } state_t;

  localparam logic [SYS_CNT_WIDTH-1:0] LP_CNT_ONE  = {{(SYS_CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2:0]               LP_RLD_LAST = 3'(RELOAD_DELAY - 1);

  logic [SYS_CNT_WIDTH-1:0] r_cnt;
  logic [7:0]               r_tima;
  logic [7:0]               r_tma;
  logic [2:0]               r_tac;
  logic                     r_edge;
  logic [2:0]               r_rcnt;
  logic                     r_irq;
  state_t                   r_state;

  logic [SYS_CNT_WIDTH-1:0] w_cnt_next;
  logic [7:0]               w_tima_next;
  logic [7:0]               w_tma_next;
  logic [2:0]               w_tac_next;
  logic [2:0]               w_rcnt_next;
  logic                     w_irq_next;
  state_t                   w_state_next;

  logic w_wr_div, w_wr_tima, w_wr_tma, w_wr_tac, w_cfg_wr;
  logic w_sig_cur, w_sig_post, w_fall, w_glitch, w_inc;

  // Counter bit chosen by TAC[1:0], gated by the TAC enable bit.
  function automatic logic sel_sig(input logic [SYS_CNT_WIDTH-1:0] cnt, input logic [2:0] tac);
    logic b;
    case (tac[1:0])
      2'b00:   b = cnt[9];
      2'b01:   b = cnt[3];
      2'b10:   b = cnt[5];
      default: b = cnt[7];
    endcase
    return tac[2] & b;
  endfunction

  assign w_wr_div  = reg_wr_in && (reg_addr_in == 2'd0);
  assign w_wr_tima = reg_wr_in && (reg_addr_in == 2'd1);
  assign w_wr_tma  = reg_wr_in && (reg_addr_in == 2'd2);
  assign w_wr_tac  = reg_wr_in && (reg_addr_in == 2'd3);
  assign w_cfg_wr  = w_wr_div | w_wr_tac;

  always_comb begin
    w_cnt_next = r_cnt;
    if (w_wr_div)     w_cnt_next = '0;
    else if (tick_in) w_cnt_next = r_cnt + LP_CNT_ONE;
  end

  assign w_tac_next = w_wr_tac ? reg_wdata_in[2:0] : r_tac;
  assign w_tma_next = w_wr_tma ? reg_wdata_in : r_tma;

  // timer_sig before this edge and as it will be after this edge's writes.
  assign w_sig_cur  = sel_sig(r_cnt, r_tac);
  assign w_sig_post = sel_sig(w_cnt_next, w_tac_next);
  assign w_fall     = r_edge & ~w_sig_cur;

`ifdef TIMER_DIV_GLITCH_EN
  assign w_glitch = w_cfg_wr & w_sig_cur & ~w_sig_post;
`else
  assign w_glitch = 1'b0;
`endif

  assign w_inc = w_fall | w_glitch;

  always_comb begin
    w_state_next = r_state;
    w_rcnt_next  = r_rcnt;
    w_tima_next  = r_tima;
    w_irq_next   = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_wr_tima) begin
          w_tima_next = reg_wdata_in;
        end else if (w_inc) begin
          if (r_tima == 8'hFF) begin
            w_tima_next  = 8'h00;
            w_state_next = ST_OVF;
            w_rcnt_next  = 3'd0;
          end else begin
            w_tima_next = r_tima + 8'd1;
          end
        end
      end
      ST_OVF: begin
        if (w_wr_tima) begin
          // CPU write during the reload window cancels reload and irq.
          w_tima_next  = reg_wdata_in;
          w_state_next = ST_RUN;
          w_rcnt_next  = 3'd0;
        end else begin
          if (w_inc) w_tima_next = r_tima + 8'd1;
          if (tick_in) begin
            if (r_rcnt == LP_RLD_LAST) begin
              w_tima_next  = w_tma_next;
              w_irq_next   = 1'b1;
              w_state_next = ST_RELOAD;
              w_rcnt_next  = 3'd0;
            end else begin
              w_rcnt_next = r_rcnt + 3'd1;
            end
          end
        end
      end
      ST_RELOAD: begin
        // TIMA tracks TMA here; direct TIMA writes and increments are dropped.
        if (w_wr_tma) w_tima_next = reg_wdata_in;
        if (tick_in)  w_state_next = ST_RUN;
      end
      default: begin
        w_state_next = ST_RUN;
        w_rcnt_next  = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_cnt   <= '0;
      r_tima  <= 8'h00;
      r_tma   <= 8'h00;
      r_tac   <= 3'd0;
      r_edge  <= 1'b0;
      r_rcnt  <= 3'd0;
      r_irq   <= 1'b0;
      r_state <= ST_RUN;
    end else begin
      r_cnt   <= w_cnt_next;
      r_tima  <= w_tima_next;
      r_tma   <= w_tma_next;
      r_tac   <= w_tac_next;
      r_edge  <= w_cfg_wr ? w_sig_post : w_sig_cur;
      r_rcnt  <= w_rcnt_next;
      r_irq   <= w_irq_next;
      r_state <= w_state_next;
    end
  end

  always_comb begin
    reg_rdata_out = 8'h00;
    case (reg_addr_in)
      2'd0:    reg_rdata_out = r_cnt[15:8];
      2'd1:    reg_rdata_out = r_tima;
      2'd2:    reg_rdata_out = r_tma;
      default: reg_rdata_out = {5'b11111, r_tac};
    endcase
  end

  assign irq_out       = r_irq;
  assign dbg_state_out = r_state;

endmodule

// File: tb/tb_gb_timer_ctrl.sv
// Directed bench for gb_timer_ctrl: rates, overflow/reload, write priorities, DIV write and async reset.
module tb_gb_timer_ctrl;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       tick_in;
  logic       reg_wr_in;
  logic [1:0] reg_addr_in;
  logic [7:0] reg_wdata_in;
  logic [7:0] reg_rdata_out;
  logic       irq_out;
  logic [1:0] dbg_state_out;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rd;
  logic [7:0] g;
  int         irq_cnt;

  gb_timer_ctrl dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .tick_in      (tick_in),
    .reg_wr_in    (reg_wr_in),
    .reg_addr_in  (reg_addr_in),
    .reg_wdata_in (reg_wdata_in),
    .reg_rdata_out(reg_rdata_out),
    .irq_out      (irq_out),
    .dbg_state_out(dbg_state_out)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  task automatic do_reset();
    rst_in = 1'b1; tick_in = 1'b0; reg_wr_in = 1'b0; reg_addr_in = 2'd1; reg_wdata_in = 8'h00;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
  endtask

  // checker
  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // drivers
  task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
    reg_wr_in = 1'b1; reg_addr_in = a; reg_wdata_in = d;
    @(negedge clk_in);
    reg_wr_in = 1'b0; reg_addr_in = 2'd1;
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [7:0] d);
    reg_addr_in = a;
    #1 d = reg_rdata_out;
    reg_addr_in = 2'd1;
  endtask

  task automatic run_ticks(input int n);
    tick_in = 1'b1;
    repeat (n) @(negedge clk_in);
    tick_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // TAC=05, TMA=AB, TIMA=FE, then 31 ticks: TIMA is FF, counter at 31.
  task automatic setup_ovf();
    do_reset();
    wr_reg(2'd3, 8'h05);
    wr_reg(2'd2, 8'hAB);
    wr_reg(2'd1, 8'hFE);
    run_ticks(31);
  endtask

  initial begin
    // reset values
    do_reset();
    rd_reg(2'd0, rd); check_val("rst_div", rd, 8'h00);
    rd_reg(2'd1, rd); check_val("rst_tima", rd, 8'h00);
    rd_reg(2'd2, rd); check_val("rst_tma", rd, 8'h00);
    rd_reg(2'd3, rd); check_val("rst_tac", rd, 8'hF8);
    check_val("rst_irq", irq_out, 1'b0);

    // TAC readback: upper bits discarded
    wr_reg(2'd3, 8'hFD); rd_reg(2'd3, rd); check_val("tac_fd", rd, 8'hFD);
    wr_reg(2'd3, 8'h02); rd_reg(2'd3, rd); check_val("tac_02", rd, 8'hFA);

    // TAC=05: increment every 16 ticks, DIV=1 after 256
    do_reset();
    wr_reg(2'd3, 8'h05);
    run_ticks(16);
    rd_reg(2'd1, rd); check_val("inc_lat0", rd, 8'h00);
    idle(1);
    rd_reg(2'd1, rd); check_val("inc_16", rd, 8'h01);
    run_ticks(239); idle(1);
    rd_reg(2'd1, rd); check_val("inc_255", rd, 8'h0F);
    rd_reg(2'd0, rd); check_val("div_255", rd, 8'h00);
    run_ticks(1); idle(1);
    rd_reg(2'd1, rd); check_val("inc_256", rd, 8'h10);
    rd_reg(2'd0, rd); check_val("div_256", rd, 8'h01);

    // TAC=04: period 1024; TAC=01 disabled: no increments
    do_reset();
    wr_reg(2'd3, 8'h04);
    run_ticks(1023); idle(1);
    rd_reg(2'd1, rd); check_val("p1024_a", rd, 8'h00);
    run_ticks(1); idle(1);
    rd_reg(2'd1, rd); check_val("p1024_b", rd, 8'h01);
    do_reset();
    wr_reg(2'd3, 8'h06);
    run_ticks(64); idle(1);
    rd_reg(2'd1, rd); check_val("p64", rd, 8'h01);
    do_reset();
    wr_reg(2'd3, 8'h01);
    run_ticks(48); idle(1);
    rd_reg(2'd1, rd); check_val("tac_dis", rd, 8'h00);

    // overflow and reload sequence
    setup_ovf();
    rd_reg(2'd1, rd); check_val("pre_ovf", rd, 8'hFF);
    exp_q = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'hAB, 8'hAB};
    irq_cnt = 0;
    tick_in = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_in);
      #1;
      check_val($sformatf("ovf_tima%0d", i), reg_rdata_out, exp_q.pop_front());
      check_val($sformatf("ovf_irq%0d", i), irq_out, (i == 5) ? 1'b1 : 1'b0);
      if (irq_out) irq_cnt++;
    end
    tick_in = 1'b0;
    check_val("irq_pulses", irq_cnt, 1);
    check_val("ovf_state", dbg_state_out, 2'd0);

    // TIMA write on second OVF tick cancels reload
    setup_ovf();
    tick_in = 1'b1;
    idle(3);
    check_val("ovf_entered", dbg_state_out, 2'd1);
    wr_reg(2'd1, 8'h10);
    irq_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      check_val($sformatf("cancel_tima%0d", i), reg_rdata_out, 8'h10);
      if (irq_out) irq_cnt++;
      @(negedge clk_in);
    end
    tick_in = 1'b0;
    check_val("cancel_irq", irq_cnt, 0);
    check_val("cancel_state", dbg_state_out, 2'd0);

    // RELOAD: TIMA write ignored, TMA write propagates to TIMA
    setup_ovf();
    tick_in = 1'b1;
    idle(6);
    tick_in = 1'b0;
    check_val("rld_state", dbg_state_out, 2'd2);
    wr_reg(2'd1, 8'h77);
    rd_reg(2'd1, rd); check_val("rld_tima_wr", rd, 8'hAB);
    tick_in = 1'b1;
    wr_reg(2'd2, 8'h55);
    tick_in = 1'b0;
    rd_reg(2'd1, rd); check_val("rld_tma_tima", rd, 8'h55);
    rd_reg(2'd2, rd); check_val("rld_tma", rd, 8'h55);
    check_val("rld_exit", dbg_state_out, 2'd0);

    // DIV write while bit 3 is high
`ifdef TIMER_DIV_GLITCH_EN
    g = 8'd1;
`else
    g = 8'd0;
`endif
    do_reset();
    wr_reg(2'd3, 8'h05);
    run_ticks(264); idle(1);
    rd_reg(2'd1, rd); check_val("div_pre_tima", rd, 8'h10);
    rd_reg(2'd0, rd); check_val("div_pre_div", rd, 8'h01);
    wr_reg(2'd0, 8'h5A); idle(1);
    rd_reg(2'd0, rd); check_val("div_clr", rd, 8'h00);
    rd_reg(2'd1, rd); check_val("div_glitch", rd, 8'h10 + g);
    run_ticks(15); idle(1);
    rd_reg(2'd1, rd); check_val("div_cnt15", rd, 8'h10 + g);
    run_ticks(1); idle(1);
    rd_reg(2'd1, rd); check_val("div_cnt16", rd, 8'h11 + g);

    // async reset while in OVF
    setup_ovf();
    tick_in = 1'b1;
    idle(3);
    check_val("rst_ovf_pre", dbg_state_out, 2'd1);
    rst_in = 1'b1;
    #1;
    check_val("arst_state", dbg_state_out, 2'd0);
    check_val("arst_irq", irq_out, 1'b0);
    rd_reg(2'd1, rd); check_val("arst_tima", rd, 8'h00);
    rd_reg(2'd2, rd); check_val("arst_tma", rd, 8'h00);
    rd_reg(2'd3, rd); check_val("arst_tac", rd, 8'hF8);
    idle(2);
    rst_in = 1'b0;
    irq_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_in);
      if (irq_out) irq_cnt++;
    end
    tick_in = 1'b0;
    check_val("arst_no_irq", irq_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
